// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, bit positions, cause codes and mstatus layout
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTI_BIT  = 7;
  localparam int MEI_BIT  = 11;

  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

  // Reserved fields are only ever loaded with zero, so the struct reads back as mstatus directly.
  typedef struct packed {
    logic [23:0] rsv_hi;
    logic        mpie;
    logic [2:0]  rsv_mid;
    logic        mie;
    logic [2:0]  rsv_lo;
  } mstatus_t;

endpackage

// File: rtl/csr_cycle_counter.sv
// rtl/csr_cycle_counter.sv - 64-bit free-running cycle counter with per-half write ports
module csr_cycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [31:0] count_lo,
  output logic [31:0] count_hi
);

  logic lo_wrap;

  // A written low half does not wrap, so it never carries.
  assign lo_wrap = (count_lo == 32'hFFFF_FFFF) && !wr_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_lo <= '0;
      count_hi <= '0;
    end else begin
      count_lo <= wr_lo ? wdata : count_lo + 32'd1;
      if (wr_hi) begin
        count_hi <= wdata;
      end else if (lo_wrap) begin
        count_hi <= count_hi + 32'd1;
      end
    end
  end

endmodule

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file with timer/external trap entry and mret redirect
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] HARTID      = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        csr_rd,
  input  logic        csr_wr,
  input  logic        is_mret,
  input  logic        timer_intr,
  input  logic        ext_intr,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        epc_taken
);

  mstatus_t    mstatus;
  logic        mtie, meie, mtip, meip;
  logic [31:0] mtvec, mepc, mcause;
  logic [31:0] cyc_lo, cyc_hi;
  logic        ext_pend, tmr_pend, irq, trap, wr_en;
  logic [31:0] cause, base, trap_target, rd_val;

  assign ext_pend    = mstatus.mie & meie & meip;
  assign tmr_pend    = mstatus.mie & mtie & mtip;
  assign irq         = ext_pend | tmr_pend;
  assign trap        = !rst && !is_mret && irq;
  assign cause       = ext_pend ? CAUSE_MEI : CAUSE_MTI;
  assign base        = {mtvec[31:2], 2'b00};
  assign trap_target = (mtvec[1:0] == 2'b01) ? base + {25'd0, cause[4:0], 2'b00} : base;
  assign epc_taken   = !rst && (is_mret || irq);
  assign epc         = trap ? trap_target : mepc;
  // The instruction in a redirect cycle is flushed, so its CSR write is dropped.
  assign wr_en       = csr_wr && !epc_taken;

  always_comb begin
    rd_val = '0;
    unique case (addr)
      CSR_MSTATUS: rd_val = mstatus;
      CSR_MIE:     begin rd_val[MTI_BIT] = mtie; rd_val[MEI_BIT] = meie; end
      CSR_MTVEC:   rd_val = mtvec;
      CSR_MEPC:    rd_val = mepc;
      CSR_MCAUSE:  rd_val = mcause;
      CSR_MIP:     begin rd_val[MTI_BIT] = mtip; rd_val[MEI_BIT] = meip; end
      CSR_MCYCLE:  rd_val = cyc_lo;
      CSR_MCYCLEH: rd_val = cyc_hi;
      // mhartid is not decoded; HARTID is reserved and contributes nothing.
      default:     rd_val = HARTID & 32'd0;
    endcase
  end

  assign rdata = csr_rd ? rd_val : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus <= '0;
      mtie    <= 1'b0;
      meie    <= 1'b0;
      mtip    <= 1'b0;
      meip    <= 1'b0;
      mtvec   <= RESET_MTVEC;
      mepc    <= '0;
      mcause  <= '0;
    end else begin
      mtip <= timer_intr;
      meip <= ext_intr;
      if (is_mret) begin
        mstatus.mie  <= mstatus.mpie;
        mstatus.mpie <= 1'b1;
      end else if (irq) begin
        mepc         <= pc;
        mcause       <= cause;
        mstatus.mpie <= mstatus.mie;
        mstatus.mie  <= 1'b0;
      end else if (wr_en) begin
        case (addr)
          CSR_MSTATUS: begin
            mstatus.mie  <= wdata[MIE_BIT];
            mstatus.mpie <= wdata[MPIE_BIT];
          end
          CSR_MIE: begin
            mtie <= wdata[MTI_BIT];
            meie <= wdata[MEI_BIT];
          end
          CSR_MTVEC:  mtvec  <= wdata;
          CSR_MEPC:   mepc   <= {wdata[31:2], 2'b00};
          CSR_MCAUSE: mcause <= wdata;
          default: ;
        endcase
      end
    end
  end

  csr_cycle_counter u_cycle (
    .clk      (clk),
    .rst      (rst),
    .wr_lo    (wr_en && (addr == CSR_MCYCLE)),
    .wr_hi    (wr_en && (addr == CSR_MCYCLEH)),
    .wdata    (wdata),
    .count_lo (cyc_lo),
    .count_hi (cyc_hi)
  );

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR register file and trap unit for the 3-stage RV32I pipeline.
- Sits in the execute/writeback stage, directly downstream of the instruction decoder. Consumes the decoder's csr_rd, csr_wr and is_mret strobes.
- Holds the machine CSRs and a 64-bit cycle counter.
- Takes timer and external interrupts, and produces the redirect target and flag that the PC mux uses for trap entry and mret.

Parameters:
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec.
- HARTID, 32'd0, reserved. mhartid is not implemented; reads of its address return 0 like any unimplemented CSR.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- addr  input  12  CSR address (inst[31:20])
- wdata  input  32  CSR write data (rs1 / ALU result)
- pc  input  32  PC of instruction in this stage
- csr_rd  input  1  read strobe from decoder
- csr_wr  input  1  write strobe from decoder
- is_mret  input  1  mret strobe from decoder
- timer_intr  input  1  level timer interrupt request
- ext_intr  input  1  level external interrupt request
- rdata  output  32  CSR read data
- epc  output  32  redirect target
- epc_taken  output  1  redirect PC to epc this cycle

Behaviour:
- **Implemented CSRs:**
  - mstatus 0x300: MIE bit 3 and MPIE bit 7 writable; all other bits read 0.
  - mie 0x304: MTIE bit 7 and MEIE bit 11 writable.
  - mtvec 0x305: all 32 bits writable.
  - mepc 0x341: bits [1:0] forced to 0 on write.
  - mcause 0x342: full 32 bits.
  - mip 0x344: read-only; MTIP bit 7 and MEIP bit 11.
  - mcycle 0xB00 and mcycleh 0xB80.
  - Any other address: reads 0, writes ignored.
- **Reset** (rst high at a posedge). All of the following take effect on the next cycle:
  - mstatus, mie, mepc, mcause, mip and mcycle all 0.
  - mtvec = RESET_MTVEC.
  - rdata = 0, epc_taken = 0, epc = 0.
  - Reset overrides every other event in the same cycle.
- **Read:** combinational. rdata = selected CSR when csr_rd = 1, else 0.
  - A same-cycle write is not visible: rdata shows the pre-write value (CSRRW semantics).
- **Write:** when csr_wr = 1 and no trap is taken, the addressed CSR updates at the posedge.
- **mip sampling:** MTIP <= timer_intr and MEIP <= ext_intr every cycle, giving one cycle of sampling latency.
- **mcycle:** increments by 1 every cycle, with a 64-bit wrap from all-ones to 0.
  - A write to mcycle or mcycleh replaces that half for the next cycle, instead of incrementing.
  - The other half is unaffected by the write.
  - A low-half wrap carries into the high half unless the high half is being written.
- **Interrupt pending:** irq = mstatus.MIE & ((mie.MEIE & mip.MEIP) | (mie.MTIE & mip.MTIP)).
- **Priority, highest first:** reset, is_mret, external interrupt, timer interrupt, CSR write.
- **mret** (is_mret = 1), in the same cycle (combinational):
  - epc_taken = 1, epc = mepc.
- **mret**, at the posedge:
  - mstatus.MIE <= MPIE and MPIE <= 1.
  - No interrupt is taken that cycle. A pending interrupt is taken on a later cycle once MIE = 1.
- **Trap entry** (irq = 1 and is_mret = 0), in the same cycle (combinational):
  - epc_taken = 1.
  - cause = 32'h8000_000B (external) or 32'h8000_0007 (timer).
  - epc = {mtvec[31:2],2'b00} when mtvec[1:0] = 00 (direct mode).
  - epc = {mtvec[31:2],2'b00} + 4*cause[4:0] when mtvec[1:0] = 01 (vectored mode).
  - mtvec[1:0] of 10 or 11 is treated as direct.
- **Trap entry**, at the posedge:
  - mepc <= pc and mcause <= cause.
  - MPIE <= MIE and MIE <= 0.
  - A CSR write in the same cycle is suppressed, because the trapped instruction is flushed.
  - mcycle still increments.
- **Re-entry:** blocked, because MIE = 0 after entry. The interrupt request stays pending until the handler clears its source; MIE is restored by mret.
- **No redirect:** when there is no trap and no mret, epc_taken = 0 and epc = mepc (a don't-care value that is held stable).
- **Mid-operation reset:** any pending redirect is dropped and no state is retained.

Decomposition:
- **Shared package csr_pkg:**
  - CSR address localparams (CSR_MSTATUS … CSR_MCYCLEH).
  - Bit-index constants MIE_BIT = 3, MPIE_BIT = 7, MTI_BIT = 7, MEI_BIT = 11.
  - Cause codes CAUSE_MTI and CAUSE_MEI.
  - Packed struct mstatus_t.
- **Sub-module:** one natural sub-module, csr_cycle_counter, holding the 64-bit counter with split-half write ports.

Test Plan:
- Reset then read: rst 1 cycle, then csr_rd addr 0x305 -> rdata = RESET_MTVEC; rdata for 0x300, 0x341 and 0x342 = 0; epc_taken = 0.
- CSRRW read-old: mepc = 0x100; csr_rd = csr_wr = 1, addr 0x341, wdata 0x207 -> rdata = 0x100 that cycle; next read = 0x204.
- Timer trap, direct mode: mtvec = 0x80, MIE = 1, MTIE = 1; raise timer_intr -> epc_taken = 1 exactly one cycle later (sampling latency), with epc = 0x80. After that, mepc = pc, mcause = 0x8000_0007, MIE = 0, MPIE = 1, and no re-trap while timer_intr is held.
- Vectored and priority: mtvec = 0x101, MEIE = MTIE = 1, both interrupt lines high -> epc = 0x100 + 44 = 0x12C and mcause = 0x8000_000B; a simultaneous csr_wr to 0x305 has no effect.
- mret with interrupt pending: in the handler, mepc = 0x40 and MPIE = 1, timer line still high, is_mret = 1 -> that cycle epc_taken = 1 with epc = 0x40 and no trap; next cycle MIE = 1 and a trap is taken.
- Counter wrap: write mcycle = 0xFFFF_FFFF, no write to mcycleh -> next cycle mcycle = 0 and mcycleh incremented by 1; writing mcycleh in the same wrap cycle -> mcycleh = wdata.
